// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 job scheduler: command codes, scheduler states, defaults.
// Latency: n/a (package only).
// Backpressure: n/a.
package sm4_pkg;

  localparam logic [1:0] SM4_CMD_PAUSE = 2'b00;
  localparam logic [1:0] SM4_CMD_KEY   = 2'b01;
  localparam logic [1:0] SM4_CMD_ENC   = 2'b10;
  localparam logic [1:0] SM4_CMD_DEC   = 2'b11;

  localparam int SM4_TMO_CYC = 1024;
  localparam int SM4_CNT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_FETCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } sched_state_e;

  // Only encrypt and decrypt are legal job modes; pause/key are wrapper-internal.
  function automatic logic cmd_is_valid(input logic [1:0] cmd);
    return (cmd != SM4_CMD_PAUSE) && (cmd != SM4_CMD_KEY);
  endfunction

endpackage

// File: rtl/sm4_watchdog.sv
// Handshake watchdog: counts enabled cycles, flags expiry on the TMO_CYC-th consecutive cycle.
// Latency: expire_o is combinational from the count register.
// Backpressure: none; clr_i restarts the count (owner clears it on every state change).
module sm4_watchdog
  import sm4_pkg::*;
#(
  parameter int TMO_CYC = SM4_TMO_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TMO_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count enabled cycles and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/sm4_job_scheduler.sv
// Sequences one SM4 job: key expansion, then per group pair read -> engine -> write-back.
// Latency per pair: rd latency + 1 + engine latency + wr latency + 1; pairs never overlap.
// Backpressure: every handshake waits indefinitely for its ack, bounded by the watchdog (-> job_err).
module sm4_job_scheduler
  import sm4_pkg::*;
#(
  parameter int TMO_CYC = SM4_TMO_CYC,
  parameter int CNT_W   = SM4_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_start_i,
  input  logic [1:0]       job_cmd_i,
  input  logic [127:0]     job_key_i,
  input  logic [CNT_W-1:0] job_base_i,
  input  logic [CNT_W-1:0] job_count_i,
  output logic             job_busy_o,
  output logic             job_done_o,
  output logic             job_err_o,
  output logic             rd_req_o,
  output logic [CNT_W-1:0] rd_idx_o,
  input  logic             rd_ack_i,
  input  logic [255:0]     rd_data_i,
  output logic             eng_start_o,
  output logic [127:0]     eng_key_o,
  output logic [1:0]       eng_cmd_o,
  output logic [255:0]     eng_din_o,
  output logic             eng_send_o,
  input  logic             eng_key_vld_i,
  input  logic             eng_round_ok_i,
  input  logic [255:0]     eng_dout_i,
  output logic             eng_out_ok_o,
  output logic             wr_req_o,
  output logic [CNT_W-1:0] wr_idx_o,
  output logic [255:0]     wr_data_o,
  output logic [1:0]       wr_mask_o,
  input  logic             wr_ack_i
);

  sched_state_e     state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [255:0]     pair_q, pair_d;
  logic [255:0]     res_q, res_d;

  logic last_grp;
  logic wd_en, wd_clr, wd_expire;

  // A single trailing group means the pair is half-populated.
  assign last_grp = (rem_q == CNT_W'(1));

  assign wd_en  = (state_q == ST_KEYEXP) || (state_q == ST_FETCH) ||
                  (state_q == ST_WAIT)   || (state_q == ST_WRITE);
  assign wd_clr = (state_d != state_q);

  sm4_watchdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  assign job_busy_o = (state_q != ST_IDLE);
  assign eng_key_o  = key_q;
  assign eng_cmd_o  = cmd_q;
  assign eng_din_o  = pair_q;

  // Next-state and per-state outputs; a handshake seen in the expiry cycle still wins.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    cmd_d        = cmd_q;
    cur_d        = cur_q;
    rem_d        = rem_q;
    pair_d       = pair_q;
    res_d        = res_q;
    job_done_o   = 1'b0;
    job_err_o    = 1'b0;
    rd_req_o     = 1'b0;
    rd_idx_o     = '0;
    eng_start_o  = 1'b0;
    eng_send_o   = 1'b0;
    eng_out_ok_o = 1'b0;
    wr_req_o     = 1'b0;
    wr_idx_o     = '0;
    wr_data_o    = '0;
    wr_mask_o    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (job_start_i) begin
          key_d = job_key_i;
          cmd_d = job_cmd_i;
          cur_d = job_base_i;
          rem_d = job_count_i;
          if (!cmd_is_valid(job_cmd_i)) begin
            state_d = ST_ERR;
          end else if (job_count_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_KEYEXP;
          end
        end
      end
      ST_KEYEXP: begin
        eng_start_o = 1'b1;
        if (eng_key_vld_i) begin
          state_d = ST_FETCH;
        end else if (wd_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_FETCH: begin
        eng_start_o = 1'b1;
        rd_req_o    = 1'b1;
        rd_idx_o    = cur_q;
        if (rd_ack_i) begin
          pair_d  = last_grp ? {128'd0, rd_data_i[127:0]} : rd_data_i;
          state_d = ST_SEND;
        end else if (wd_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_SEND: begin
        eng_start_o = 1'b1;
        eng_send_o  = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        eng_start_o = 1'b1;
        eng_send_o  = 1'b1;
        if (eng_round_ok_i) begin
          res_d   = eng_dout_i;
          state_d = ST_WRITE;
        end else if (wd_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_WRITE: begin
        eng_start_o = 1'b1;
        wr_req_o    = 1'b1;
        wr_idx_o    = cur_q;
        wr_data_o   = res_q;
        wr_mask_o   = last_grp ? 2'b01 : 2'b11;
        if (wr_ack_i) begin
          eng_out_ok_o = 1'b1;
          cur_d        = cur_q + CNT_W'(2);
          rem_d        = (rem_q > CNT_W'(2)) ? (rem_q - CNT_W'(2)) : '0;
          state_d      = (rem_q > CNT_W'(2)) ? ST_FETCH : ST_DONE;
        end else if (wd_expire) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        job_done_o = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        job_err_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cmd_q   <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      pair_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cmd_q   <= cmd_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      pair_q  <= pair_d;
      res_q   <= res_d;
    end
  end

endmodule
